max_pool_layer: RTL and testbench
=================================

MAX_POOL_LAYER -- requirements
Module: max_pool_layer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: signed fixed-point sample width with 6 fractional bits. Values pass through unchanged.
REQ-002 SHALL have parameter NUM_FILTERS, default 5: number of feature maps.
REQ-003 SHALL have parameter IN_DIM, default 28: input map edge, even. Output edge OUT_DIM = IN_DIM/2.
REQ-004 SHALL have port clk, input, 1: clock. All state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: level request. Rising level begins a pass; dropping it acknowledges done.
REQ-007 SHALL have port sig_layer, input, signed DATA_WIDTH [NUM_FILTERS][IN_DIM][IN_DIM]: sigmoid feature maps from the convolution layer. Must be held stable from start until done.
REQ-008 SHALL have port max_pooling, output, signed DATA_WIDTH [NUM_FILTERS][OUT_DIM][OUT_DIM]: registered pooled maps.
REQ-009 SHALL have port max_idx, output, 2-bit [NUM_FILTERS][OUT_DIM][OUT_DIM]: registered winner position inside each window, encoded as 0=(0,0), 1=(0,1), 2=(1,0), 3=(1,1) (row offset, col offset). Used by backprop.
REQ-010 SHALL have port done, output, 1: registered completion flag.

Function
REQ-011 SHALL implement states IDLE, COMPUTING and DONE. An unknown state SHALL go to IDLE.
REQ-012 IDLE: when start=1 at a clock edge, the block SHALL go to COMPUTING, with counters f, i, j all 0.
REQ-013 COMPUTING SHALL produce exactly one output per cycle for window (f,i,j), covering input rows 2i..2i+1 and columns 2j..2j+1. Each cycle it SHALL write max_pooling[f][i][j] and max_idx[f][i][j].
REQ-014 Counter order SHALL be j fastest, then i, then f. On the cycle that writes (NUM_FILTERS-1, OUT_DIM-1, OUT_DIM-1), the block SHALL go to DONE and the counters SHALL wrap to 0.
REQ-015 Comparisons SHALL be signed, two's complement, at full DATA_WIDTH, with no saturation or truncation.
REQ-016 On ties, the earliest position in scan order 0,1,2,3 SHALL win (strict greater-than replaces the current winner).
REQ-017 Latency with defaults: the edge that samples start=1 is edge 0. Outputs SHALL be written on edges 1..980. done SHALL be 1 after edge 981, i.e. one edge after entering DONE.
REQ-018 DONE: done SHALL stay 1 while start=1. When start=0 at an edge, the block SHALL go to IDLE and clear done on that same edge.
REQ-019 A change of start during COMPUTING SHALL be ignored, and the pass SHALL complete.
REQ-020 Outside COMPUTING, max_pooling and max_idx SHALL hold their values. A new pass SHALL overwrite every entry; entries are not pre-cleared.

Reset
REQ-021 When rst_n=0, regardless of clk, the block SHALL force: state IDLE, counters 0, done 0, every max_pooling entry 0, every max_idx entry 0.
REQ-022 If reset asserts mid-pass, the partial results SHALL be discarded by these zeros. The next start after release SHALL run a complete pass from window (0,0,0).

Verification
REQ-023 Reset and idle: assert rst_n=0 with random sig_layer. All outputs SHALL be 0 and done SHALL be 0. After release with start=0 for 50 cycles, all outputs SHALL still be 0.
REQ-024 Single peak: all inputs 0 except sig_layer[2][5][7]=100. Expect max_pooling[2][2][3]=100 with max_idx 3. All other max_pooling entries SHALL be 0 with max_idx 0.
REQ-025 Signed compare and tie: window (0,0,0) = {-5,-3,-300,-4} -> max -3, idx 1. Window (0,0,1) = {17,17,17,17} -> max 17, idx 0. Window (4,13,13) = {-512,-512,-512,511} -> max 511, idx 3.
REQ-026 Handshake timing: done SHALL rise exactly 981 cycles after start is sampled and SHALL stay 1 for 20 further cycles with start=1. Dropping start SHALL clear done on the next edge. A second start with new data SHALL give correct results and done again after 981 cycles.
REQ-027 Mid-pass reset: pulse rst_n low at cycle 400 of COMPUTING. All outputs SHALL be 0 and the state IDLE. A new start SHALL then yield a full, correct result that matches the reference model for all 980 windows.
REQ-028 Start glitch: drop start at cycle 100 of COMPUTING. The pass SHALL complete with a bit-exact result, DONE SHALL be reached on schedule, and the block SHALL return to IDLE on the following edge because start=0.

Source files
------------

// File: rtl/max_pool_layer.sv
// 2x2 stride-2 max pooling over NUM_FILTERS maps, one window per cycle, with winner index for backprop.
// Pass takes NUM_FILTERS*OUT_DIM*OUT_DIM cycles; start is a level handshake held until done is seen.
module max_pool_layer #(
  parameter int DATA_WIDTH  = 10,
  parameter int NUM_FILTERS = 5,
  parameter int IN_DIM      = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] sig_layer   [NUM_FILTERS][IN_DIM][IN_DIM],
  output logic signed [DATA_WIDTH-1:0] max_pooling [NUM_FILTERS][IN_DIM/2][IN_DIM/2],
  output logic        [1:0]            max_idx     [NUM_FILTERS][IN_DIM/2][IN_DIM/2],
  output logic                         done
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int FW      = $clog2(NUM_FILTERS);
  localparam int OW      = $clog2(OUT_DIM);
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t state, state_nxt;
  logic [FW-1:0] f;
  logic [OW-1:0] i, j;
  logic last_win;

  logic signed [DATA_WIDTH-1:0] win [4];
  logic signed [DATA_WIDTH-1:0] best;
  logic        [1:0]            best_idx;

  assign last_win = (f == F_LAST) && (i == O_LAST) && (j == O_LAST);

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:      state_nxt = start ? COMPUTING : IDLE;
      COMPUTING: state_nxt = last_win ? DONE : COMPUTING;
      DONE:      state_nxt = start ? DONE : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Scan order 0..3 with strict '>' keeps the earliest position on ties.
  always_comb begin
    win[0]   = sig_layer[f][{i, 1'b0}][{j, 1'b0}];
    win[1]   = sig_layer[f][{i, 1'b0}][{j, 1'b1}];
    win[2]   = sig_layer[f][{i, 1'b1}][{j, 1'b0}];
    win[3]   = sig_layer[f][{i, 1'b1}][{j, 1'b1}];
    best     = win[0];
    best_idx = 2'd0;
    for (int k = 1; k < 4; k++) begin
      if (win[k] > best) begin
        best     = win[k];
        best_idx = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      f     <= '0;
      i     <= '0;
      j     <= '0;
      done  <= 1'b0;
      for (int a = 0; a < NUM_FILTERS; a++)
        for (int b = 0; b < OUT_DIM; b++)
          for (int c = 0; c < OUT_DIM; c++) begin
            max_pooling[a][b][c] <= '0;
            max_idx[a][b][c]     <= '0;
          end
    end else begin
      state <= state_nxt;
      done  <= (state == DONE) && start;
      if (state == COMPUTING) begin
        max_pooling[f][i][j] <= best;
        max_idx[f][i][j]     <= best_idx;
        // Counters wrap to zero after the last window, ready for the next pass.
        if (j == O_LAST) begin
          j <= '0;
          if (i == O_LAST) begin
            i <= '0;
            f <= (f == F_LAST) ? '0 : f + 1'b1;
          end else begin
            i <= i + 1'b1;
          end
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer: reset, single peak, signed/tie windows, handshake, mid-pass reset, start glitch.
module tb_max_pool_layer;

  localparam int DW = 10;
  localparam int NF = 5;
  localparam int ID = 28;
  localparam int OD = ID / 2;

  logic clk;
  logic rst_n;
  logic start;
  logic signed [DW-1:0] sig    [NF][ID][ID];
  logic signed [DW-1:0] mp     [NF][OD][OD];
  logic        [1:0]    mi     [NF][OD][OD];
  logic                 done;

  logic signed [DW-1:0] exp_mp [NF][OD][OD];
  logic        [1:0]    exp_mi [NF][OD][OD];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int cnt;

  max_pool_layer #(.DATA_WIDTH(DW), .NUM_FILTERS(NF), .IN_DIM(ID)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sig_layer   (sig),
    .max_pooling (mp),
    .max_idx     (mi),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic fill_zero();
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < ID; r++)
        for (int c = 0; c < ID; c++)
          sig[f][r][c] = '0;
  endtask

  task automatic fill_rand();
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < ID; r++)
        for (int c = 0; c < ID; c++)
          sig[f][r][c] = DW'($urandom);
  endtask

  // Reference: walk the window in (row,col) order, keep the first strict maximum.
  task automatic model();
    logic signed [DW-1:0] v;
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < OD; i++)
        for (int j = 0; j < OD; j++) begin
          exp_mp[f][i][j] = sig[f][2*i][2*j];
          exp_mi[f][i][j] = 2'd0;
          for (int p = 1; p < 4; p++) begin
            v = sig[f][2*i + p/2][2*j + p%2];
            if (v > exp_mp[f][i][j]) begin
              exp_mp[f][i][j] = v;
              exp_mi[f][i][j] = 2'(p);
            end
          end
        end
  endtask

  function automatic int model_errs();
    int e = 0;
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < OD; i++)
        for (int j = 0; j < OD; j++)
          if (mp[f][i][j] !== exp_mp[f][i][j] || mi[f][i][j] !== exp_mi[f][i][j]) e++;
    return e;
  endfunction

  function automatic int nonzero_except(input int sf, input int si, input int sj);
    int e = 0;
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < OD; i++)
        for (int j = 0; j < OD; j++)
          if (!(f == sf && i == si && j == sj) && (mp[f][i][j] !== '0 || mi[f][i][j] !== '0)) e++;
    return e;
  endfunction

  task automatic begin_pass();
    @(negedge clk);
    start  = 1'b1;
    edge_n = -1;
  endtask

  task automatic run_to_done(input string tag);
    while (!done && edge_n < 2000) step();
    check(tag, edge_n, 981);
  endtask

  task automatic end_pass();
    @(negedge clk);
    start = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill_rand();

    // Reset with random inputs applied.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs_zero", nonzero_except(-1, -1, -1), 0);
    check("rst_done", done, 0);
    check("rst_state", int'(dut.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) step();
    check("idle_outputs_zero", nonzero_except(-1, -1, -1), 0);
    check("idle_done", done, 0);

    // Single peak.
    fill_zero();
    sig[2][5][7] = 10'sd100;
    model();
    begin_pass();
    run_to_done("peak_latency");
    check("peak_val", mp[2][2][3], 100);
    check("peak_idx", mi[2][2][3], 3);
    check("peak_others_zero", nonzero_except(2, 2, 3), 0);
    cnt = 0;
    repeat (20) begin
      step();
      if (done) cnt++;
    end
    check("done_hold", cnt, 20);
    end_pass();
    check("done_clear", done, 0);

    // Signed compare and ties, second pass over fresh data.
    fill_zero();
    sig[0][0][0] = -10'sd5;   sig[0][0][1] = -10'sd3;
    sig[0][1][0] = -10'sd300; sig[0][1][1] = -10'sd4;
    sig[0][0][2] = 10'sd17;   sig[0][0][3] = 10'sd17;
    sig[0][1][2] = 10'sd17;   sig[0][1][3] = 10'sd17;
    sig[4][26][26] = -10'sd512; sig[4][26][27] = -10'sd512;
    sig[4][27][26] = -10'sd512; sig[4][27][27] = 10'sd511;
    model();
    begin_pass();
    run_to_done("tie_latency");
    check("neg_val", mp[0][0][0], -3);
    check("neg_idx", mi[0][0][0], 1);
    check("tie_val", mp[0][0][1], 17);
    check("tie_idx", mi[0][0][1], 0);
    check("ext_val", mp[4][13][13], 511);
    check("ext_idx", mi[4][13][13], 3);
    check("tie_full", model_errs(), 0);
    end_pass();

    // Mid-pass reset, then a clean pass on random data.
    fill_rand();
    model();
    begin_pass();
    while (edge_n < 400) step();
    rst_n = 1'b0;
    #1;
    check("midrst_outputs_zero", nonzero_except(-1, -1, -1), 0);
    check("midrst_done", done, 0);
    check("midrst_state", int'(dut.state), 0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    begin_pass();
    run_to_done("midrst_latency");
    check("midrst_full", model_errs(), 0);
    end_pass();

    // Start dropped mid-pass: pass completes, DONE is left immediately.
    fill_rand();
    model();
    begin_pass();
    while (edge_n < 100) step();
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (edge_n < 980) begin
      step();
      if (done) cnt++;
    end
    check("glitch_state_done", int'(dut.state), 2);
    step();
    if (done) cnt++;
    check("glitch_state_idle", int'(dut.state), 0);
    check("glitch_done_never", cnt, 0);
    check("glitch_full", model_errs(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
